data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data RAM between two requesters: port 0 is the MIPS core
//  data port, port 1 is the debug/loader port. Arbitration is round-robin with a
//  burst limit. Each granted access is latched, issued to the RAM for one cycle and
//  acknowledged with registered read data. Sits between Data_Path/loader and Ram.
// PARAMETERS
//  DATA_WIDTH  32  width of write/read data
//  ADDR_WIDTH  32  width of byte address passed to Ram
//  MAX_BURST   4   max consecutive grants to one port while the other requests (>=1)
// PORTS
//  Clk       in   1           clock; all state updates on rising edge
//  Rst       in   1           synchronous reset, active-low
//  Req0      in   1           port 0 request; held high until Ack0
//  We0       in   1           port 0 write enable (1=write, 0=read)
//  Addr0     in   ADDR_WIDTH  port 0 address
//  WData0    in   DATA_WIDTH  port 0 write data
//  Ack0      out  1           port 0 one-cycle completion pulse
//  RData0    out  DATA_WIDTH  port 0 read data, valid while Ack0=1
//  Req1/We1/Addr1/WData1/Ack1/RData1   same as port 0, for port 1
//  Mem_WE    out  1           RAM write enable
//  Mem_A     out  ADDR_WIDTH  RAM address
//  Mem_WD    out  DATA_WIDTH  RAM write data
//  Mem_RD    in   DATA_WIDTH  RAM combinational read data
//  Grant     out  2           one-hot owner during ACCESS/RESP; 2'b00 in IDLE
//  Busy      out  1           1 when state != IDLE
// BEHAVIOUR
//  Reset (Rst=0 at edge): state=IDLE, Grant=0, Ack0/1=0, RData0/1=0, Mem_WE=0,
//   Mem_A=0, Mem_WD=0, last_owner=1 (port 0 wins the first tie), burst_cnt=0.
//   Reset mid-access aborts it: no Ack is issued and Mem_WE is 0 the next cycle.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. There is one access per 3 cycles.
//  IDLE: if a requester is asserting Req, pick the winner. Latch its We/Addr/WData
//   and set Grant. Go to ACCESS. If no Req, stay in IDLE.
//  Winner selection:
//   - Only one Req asserted: that port wins.
//   - Both asserted, burst_cnt<MAX_BURST: last_owner wins again.
//   - Both asserted, burst_cnt==MAX_BURST: the other port wins.
//   - burst_cnt=1 when owner changes or the previous IDLE had no Req; else it
//     increments, saturating at MAX_BURST.
//  ACCESS: drive Mem_A/Mem_WD from the latched values. Mem_WE = latched We.
//   Capture Mem_RD into the owner's RData register at the end of the cycle.
//   Mem_WE is 1 only in ACCESS. Outside ACCESS, Mem_A and Mem_WD are 0.
//  RESP: Ack of the owner = 1 for exactly this cycle. Update last_owner. Go to IDLE.
//   The Req still high in RESP is not a new request.
//  Latency: Req sampled in IDLE at cycle T -> Mem access in T+1 -> Ack at T+2.
//  Latched operands: Req/We/Addr/WData changes after grant do not affect the access.
//  RData of the non-owner port holds its previous value.
//  RData on a write ack: the value read at Mem_A during ACCESS (pre-write data).
//  Ack0 and Ack1 are never both 1. Grant is never 2'b11.
// TESTING
//  1 Reset: Rst=0 for 2 cycles with Req0=Req1=1 -> all outputs 0, Busy=0; no Mem_WE.
//  2 Port 0 write then read:
//    - Req0, We0=1, Addr0=8, WData0=0xDEADBEEF -> Mem_WE=1, Mem_A=8 at T+1;
//      Ack0 at T+2.
//    - Then a read at Addr0=8 -> RData0=0xDEADBEEF with Ack0.
//  3 Contention with MAX_BURST=4:
//    - Req0 and Req1 both held continuously -> grant order 0,0,0,0,1,1,1,1,0.
//    - Ack cadence is exactly 1 in 3 cycles.
//  4 Single requester:
//    - Only Req1 held for 6 accesses -> all go to port 1 with no gaps beyond 3-cycle
//      cadence; Ack0 stays 0.
//  5 Operand latching: Addr1 changes 0x10->0x20 during ACCESS -> Mem_A=0x10 for
//    that access.
//  6 Reset mid-op: Rst=0 in the ACCESS cycle of a write -> no Ack1, state IDLE,
//    Mem_WE=0 next cycle.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with a burst limit that shares the single-port data RAM
// between the MIPS core data port (0) and the debug/loader port (1).
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Req0,
  input  logic                  We0,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [DATA_WIDTH-1:0] WData0,
  output logic                  Ack0,
  output logic [DATA_WIDTH-1:0] RData0,
  input  logic                  Req1,
  input  logic                  We1,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Ack1,
  output logic [DATA_WIDTH-1:0] RData1,
  output logic                  Mem_WE,
  output logic [ADDR_WIDTH-1:0] Mem_A,
  output logic [DATA_WIDTH-1:0] Mem_WD,
  input  logic [DATA_WIDTH-1:0] Mem_RD,
  output logic [1:0]            Grant,
  output logic                  Busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic          idle_gap;
  logic [CW-1:0] burst_cnt;
  logic          win;
  logic [CW-1:0] next_cnt;

  // A zero burst count only exists straight after reset, so the tie then goes
  // to the port after last_owner, which is port 0.
  always_comb begin
    win = 1'b0;
    if (Req0 && Req1) begin
      if ((burst_cnt != '0) && (burst_cnt < BURST_MAX))
        win = last_owner;
      else
        win = ~last_owner;
    end else if (Req1) begin
      win = 1'b1;
    end
  end

  always_comb begin
    next_cnt = CW'(1);
    if ((win == last_owner) && !idle_gap && (burst_cnt != '0)) begin
      if (burst_cnt < BURST_MAX)
        next_cnt = burst_cnt + CW'(1);
      else
        next_cnt = burst_cnt;
    end
  end

  // The Mem_* registers double as the latched operands of the granted access.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      idle_gap   <= 1'b0;
      burst_cnt  <= '0;
      Grant      <= 2'b00;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      RData0     <= '0;
      RData1     <= '0;
      Mem_WE     <= 1'b0;
      Mem_A      <= '0;
      Mem_WD     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            state     <= ACCESS;
            owner     <= win;
            Grant     <= win ? 2'b10 : 2'b01;
            Mem_WE    <= win ? We1 : We0;
            Mem_A     <= win ? Addr1 : Addr0;
            Mem_WD    <= win ? WData1 : WData0;
            burst_cnt <= next_cnt;
            idle_gap  <= 1'b0;
          end else begin
            idle_gap  <= 1'b1;
          end
        end
        ACCESS: begin
          state  <= RESP;
          Mem_WE <= 1'b0;
          Mem_A  <= '0;
          Mem_WD <= '0;
          if (owner) begin
            RData1 <= Mem_RD;
            Ack1   <= 1'b1;
          end else begin
            RData0 <= Mem_RD;
            Ack0   <= 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          Ack0       <= 1'b0;
          Ack1       <= 1'b0;
          Grant      <= 2'b00;
          last_owner <= owner;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: the driver queues expected acks, a
// negedge monitor pops and compares them against what the arbiter returns.
module tb_data_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0, We0, Req1, We1;
  logic [31:0] Addr0, WData0, Addr1, WData1;
  logic        Ack0, Ack1, Mem_WE, Busy;
  logic [31:0] RData0, RData1, Mem_A, Mem_WD, Mem_RD;
  logic [1:0]  Grant;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        got_exp;
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          prev_cycle = 0;
  bit          cadence_on = 1'b0;
  bit          have_prev = 1'b0;
  logic [31:0] mem [0:63];

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0), .Ack0(Ack0), .RData0(RData0),
    .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1), .Ack1(Ack1), .RData1(RData1),
    .Mem_WE(Mem_WE), .Mem_A(Mem_A), .Mem_WD(Mem_WD), .Mem_RD(Mem_RD),
    .Grant(Grant), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Word-addressed RAM model, preloaded with 0xA0000000 + word index.
  initial for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
  assign Mem_RD = mem[Mem_A[7:2]];
  always @(posedge Clk) begin
    if (Mem_WE) mem[Mem_A[7:2]] <= Mem_WD;
    cycle <= cycle + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit port, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      Req1 = req; We1 = we; Addr1 = addr; WData1 = wdata;
    end else begin
      Req0 = req; We0 = we; Addr0 = addr; WData0 = wdata;
    end
  endtask

  task automatic expectAck(input bit port, input logic [31:0] rdata);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Returns one time unit after the edge that follows the last awaited ack,
  // i.e. inside the next IDLE cycle.
  task automatic waitAcks(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge Clk);
      cyc++;
      if (Ack0 || Ack1) got++;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("[TB] FAIL ack_wait actual=%0d expected=%0d", got, n);
    end
    tick();
  endtask

  always @(negedge Clk) begin
    checkOutput("ack_exclusive", 32'(Ack0 && Ack1), 32'd0);
    checkOutput("grant_not_both", 32'(Grant == 2'b11), 32'd0);
    if (Ack0 || Ack1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack actual=Ack0:%b/Ack1:%b expected=none", Ack0, Ack1);
      end else begin
        got_exp = sb.pop_front();
        checkOutput("ack_port", 32'(Ack1), 32'(got_exp.port));
        checkOutput("ack_rdata", Ack1 ? RData1 : RData0, got_exp.rdata);
      end
      if (cadence_on && have_prev)
        checkOutput("ack_cadence", 32'(cycle - prev_cycle), 32'd3);
      prev_cycle = cycle;
      have_prev  = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 32'h8, 32'h1111_1111);
    applyStimulus(1, 1'b1, 1'b1, 32'h8, 32'h2222_2222);

    // Reset held with both ports requesting.
    repeat (2) begin
      @(negedge Clk);
      checkOutput("rst_grant", 32'(Grant), 32'd0);
      checkOutput("rst_ack0", 32'(Ack0), 32'd0);
      checkOutput("rst_ack1", 32'(Ack1), 32'd0);
      checkOutput("rst_rdata0", RData0, 32'd0);
      checkOutput("rst_rdata1", RData1, 32'd0);
      checkOutput("rst_mem_we", 32'(Mem_WE), 32'd0);
      checkOutput("rst_mem_a", Mem_A, 32'd0);
      checkOutput("rst_mem_wd", Mem_WD, 32'd0);
      checkOutput("rst_busy", 32'(Busy), 32'd0);
    end
    tick();
    Rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Port 0 write to 0x8 returns pre-write data, then reads back the new word.
    applyStimulus(0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    expectAck(0, 32'hA000_0002);
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("t2_mem_we", 32'(Mem_WE), 32'd1);
    checkOutput("t2_mem_a", Mem_A, 32'h8);
    checkOutput("t2_mem_wd", Mem_WD, 32'hDEAD_BEEF);
    checkOutput("t2_grant", 32'(Grant), 32'd1);
    checkOutput("t2_busy", 32'(Busy), 32'd1);
    @(negedge Clk);
    checkOutput("t2_ack_latency", 32'(Ack0), 32'd1);
    checkOutput("t2_mem_we_off", 32'(Mem_WE), 32'd0);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 32'h8, 32'h0);
    expectAck(0, 32'hDEAD_BEEF);
    waitAcks(1, 10);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fresh reset, then both ports held: grant order 0,0,0,0,1,1,1,1,0.
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h04, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h18, 32'h0);
    for (int k = 0; k < 4; k++) expectAck(0, 32'hA000_0001);
    for (int k = 0; k < 4; k++) expectAck(1, 32'hA000_0006);
    expectAck(0, 32'hA000_0001);
    have_prev  = 1'b0;
    cadence_on = 1'b1;
    waitAcks(9, 40);
    cadence_on = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Port 1 alone for six back-to-back accesses; port 0 data must hold.
    applyStimulus(1, 1'b1, 1'b0, 32'h0C, 32'h0);
    for (int k = 0; k < 6; k++) expectAck(1, 32'hA000_0003);
    have_prev  = 1'b0;
    cadence_on = 1'b1;
    waitAcks(6, 30);
    cadence_on = 1'b0;
    checkOutput("t4_rdata0_hold", RData0, 32'hA000_0001);

    // Address change after grant must not affect the access.
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0);
    expectAck(1, 32'hA000_0004);
    tick();
    Addr1 = 32'h20;
    @(negedge Clk);
    checkOutput("t5_mem_a_latched", Mem_A, 32'h10);
    waitAcks(1, 10);

    // Reset during the ACCESS cycle of a port 1 write aborts it.
    applyStimulus(1, 1'b1, 1'b1, 32'h14, 32'h1234_5678);
    tick();
    Rst = 1'b0;
    @(negedge Clk);
    checkOutput("t6_in_access", 32'(Mem_WE), 32'd1);
    tick();
    Rst = 1'b1;
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge Clk);
    checkOutput("t6_ack1", 32'(Ack1), 32'd0);
    checkOutput("t6_busy", 32'(Busy), 32'd0);
    checkOutput("t6_mem_we", 32'(Mem_WE), 32'd0);
    checkOutput("t6_grant", 32'(Grant), 32'd0);
    repeat (4) @(negedge Clk);
    checkOutput("t6_no_late_ack1", 32'(Ack1), 32'd0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
